// File: rtl/mlp_tx_framer_if.sv
// Handshake bundle between the MLP result stage, the tx framer and the UART sender.
// The master modport is the framer side; the slave modport is the side feeding and draining it.
interface mlp_tx_framer_if #(
    parameter int NUM_WORDS = 4,
    parameter int WORD_W    = 16
);
    logic                        start;
    logic [NUM_WORDS*WORD_W-1:0] in_words;
    logic                        tx_ready;
    logic [7:0]                  tx_data;
    logic                        newdata;
    logic                        busy;
    logic                        done;

    modport master (
        input  start, in_words, tx_ready,
        output tx_data, newdata, busy, done
    );

    modport slave (
        output start, in_words, tx_ready,
        input  tx_data, newdata, busy, done
    );
endinterface

// File: rtl/mlp_tx_framer.sv
// Frames one captured MLP result vector as HEADER + payload bytes for the UART sender.
// Define MLP_TX_FRAMER_CHECKSUM_EN to append an XOR checksum byte after the payload.
module mlp_tx_framer #(
    parameter int         NUM_WORDS = 4,
    parameter int         WORD_W    = 16,
    parameter logic [7:0] HEADER    = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    mlp_tx_framer_if.master bus
);
    localparam int BPW = WORD_W / 8;
    localparam int P   = NUM_WORDS * BPW;
    localparam int CW  = $clog2(P + 1);
    localparam int VW  = NUM_WORDS * WORD_W;
    localparam int PN  = 1 << CW;
    localparam logic [CW-1:0] LAST = CW'(P - 1);

`ifdef MLP_TX_FRAMER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]   shadow_q, shadow_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            newdata_q, newdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef MLP_TX_FRAMER_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif
    logic            xfer;
    logic [PN-1:0][7:0] payload;

    // Payload byte i is byte (BPW-1 - i%BPW) of word i/BPW; padding keeps the index full width.
    for (genvar k = 0; k < PN; k++) begin : g_pay
        if (k < P) begin : g_used
            assign payload[k] = shadow_q[(k/BPW)*WORD_W + (BPW-1 - k%BPW)*8 +: 8];
        end else begin : g_pad
            assign payload[k] = 8'h00;
        end
    end

    assign xfer = newdata_q & bus.tx_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
`ifdef MLP_TX_FRAMER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = HDR;
                    shadow_d = bus.in_words;
                    cnt_d    = '0;
`ifdef MLP_TX_FRAMER_CHECKSUM_EN
                    csum_d   = 8'h00;
`endif
                end
            end
            HDR: begin
                if (xfer) begin
                    state_d = DATA;
                    cnt_d   = '0;
`ifdef MLP_TX_FRAMER_CHECKSUM_EN
                    csum_d  = csum_q ^ HEADER;
`endif
                end
            end
            DATA: begin
                if (xfer) begin
`ifdef MLP_TX_FRAMER_CHECKSUM_EN
                    csum_d = csum_q ^ tx_data_q;
                    if (cnt_q == LAST) state_d = CSUM;
`else
                    if (cnt_q == LAST) state_d = DONE;
`endif
                    else cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef MLP_TX_FRAMER_CHECKSUM_EN
            CSUM: begin
                if (xfer) state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        newdata_d = (state_d == HDR) || (state_d == DATA);
`ifdef MLP_TX_FRAMER_CHECKSUM_EN
        newdata_d = newdata_d || (state_d == CSUM);
`endif
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        case (state_d)
            HDR:     tx_data_d = HEADER;
            DATA:    tx_data_d = payload[cnt_d];
`ifdef MLP_TX_FRAMER_CHECKSUM_EN
            CSUM:    tx_data_d = csum_d;
`endif
            default: tx_data_d = tx_data_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            tx_data_q <= 8'h00;
            newdata_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MLP_TX_FRAMER_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            tx_data_q <= tx_data_d;
            newdata_q <= newdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MLP_TX_FRAMER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign bus.tx_data = tx_data_q;
    assign bus.newdata = newdata_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
